// File: rtl/dvv_spi_slave_rsp.sv
// SPI slave responder: oversamples SCK/CS_N/MOSI on clk, shifts WIDTH-bit words MSB-first and
// feeds MISO from a one-entry transmit holding buffer.
module dvv_spi_slave_rsp #(
   parameter int unsigned      WIDTH   = 8,
   parameter bit               CPOL    = 1'b0,
   parameter bit               CPHA    = 1'b0,
   parameter logic [WIDTH-1:0] TX_IDLE = '1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             spi_sck,
   input  logic             spi_cs_n,
   input  logic             spi_mosi,
   output logic             spi_miso,
   output logic             spi_miso_oe,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic             tx_underrun,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   output logic             rx_abort,
   output logic             busy
);

   localparam int unsigned   CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
   localparam logic [0:0]    ST_IDLE  = 1'b0;
   localparam logic [0:0]    ST_SHIFT = 1'b1;

   // [0] first sync stage, [1] synchronised value, [2] previous value for edge detection
   logic [2:0] sck_q, cs_q, mosi_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sck_q  <= {3{CPOL}};
         cs_q   <= 3'b111;
         mosi_q <= 3'b000;
      end else begin
         sck_q  <= {sck_q[1:0], spi_sck};
         cs_q   <= {cs_q[1:0], spi_cs_n};
         mosi_q <= {mosi_q[1:0], spi_mosi};
      end
   end

   logic sck_rise, sck_fall, lead, trail, sample_edge, shift_edge, cs_fall, cs_rise, mosi_sync;

   assign sck_rise    = sck_q[1] & ~sck_q[2];
   assign sck_fall    = ~sck_q[1] & sck_q[2];
   assign lead        = CPOL ? sck_fall : sck_rise;
   assign trail       = CPOL ? sck_rise : sck_fall;
   assign sample_edge = CPHA ? trail : lead;
   assign shift_edge  = CPHA ? lead : trail;
   assign cs_fall     = ~cs_q[1] & cs_q[2];
   assign cs_rise     = cs_q[1] & ~cs_q[2];
   assign mosi_sync   = mosi_q[1];

   logic [0:0]       state_q, state_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
   logic [WIDTH-1:0] rx_data_q, rx_data_d;
   logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
   logic [WIDTH-1:0] buf_q, buf_d;
   logic             buf_full_q, buf_full_d;
   logic             rx_valid_q, rx_valid_d;
   logic             rx_abort_q, rx_abort_d;
   logic             tx_underrun_q, tx_underrun_d;
   logic             load;

   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      rx_shift_d    = rx_shift_q;
      rx_data_d     = rx_data_q;
      tx_shift_d    = tx_shift_q;
      buf_d         = buf_q;
      buf_full_d    = buf_full_q;
      rx_valid_d    = 1'b0;
      rx_abort_d    = 1'b0;
      tx_underrun_d = 1'b0;
      load          = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cs_fall) begin
               state_d   = ST_SHIFT;
               bit_cnt_d = '0;
               load      = ~CPHA;
            end
         end
         ST_SHIFT: begin
            if (sample_edge) begin
               rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_sync};
               if (bit_cnt_q == LAST) begin
                  rx_data_d  = rx_shift_d;
                  rx_valid_d = 1'b1;
                  bit_cnt_d  = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + CW'(1);
               end
            end
            // A final sample coinciding with the CS_N rise has already cleared bit_cnt_d.
            if (cs_rise) begin
               state_d    = ST_IDLE;
               rx_abort_d = (bit_cnt_d != '0);
               bit_cnt_d  = '0;
            end else if (shift_edge) begin
               if (bit_cnt_q == '0) begin
                  load = 1'b1;
               end else begin
                  tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (load) begin
         if (buf_full_q) begin
            tx_shift_d = buf_q;
            buf_full_d = 1'b0;
         end else begin
            tx_shift_d    = TX_IDLE;
            tx_underrun_d = 1'b1;
         end
      end

      // Only accepted while empty, so it never collides with a load that drains the buffer.
      if (tx_valid && !buf_full_q) begin
         buf_d      = tx_data;
         buf_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= ST_IDLE;
         bit_cnt_q     <= '0;
         rx_shift_q    <= '0;
         rx_data_q     <= '0;
         tx_shift_q    <= '0;
         buf_q         <= '0;
         buf_full_q    <= 1'b0;
         rx_valid_q    <= 1'b0;
         rx_abort_q    <= 1'b0;
         tx_underrun_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         rx_shift_q    <= rx_shift_d;
         rx_data_q     <= rx_data_d;
         tx_shift_q    <= tx_shift_d;
         buf_q         <= buf_d;
         buf_full_q    <= buf_full_d;
         rx_valid_q    <= rx_valid_d;
         rx_abort_q    <= rx_abort_d;
         tx_underrun_q <= tx_underrun_d;
      end
   end

   assign busy        = (state_q == ST_SHIFT);
   assign spi_miso_oe = busy;
   assign spi_miso    = tx_shift_q[WIDTH-1];
   assign tx_ready    = ~buf_full_q;
   assign tx_underrun = tx_underrun_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign rx_abort    = rx_abort_q;

endmodule

// File: tb/tb_dvv_spi_slave_rsp.sv
// Bench for dvv_spi_slave_rsp: one instance per SPI mode, directed table plus randomized frames
// checked against a queue-based model of load points and the holding buffer.
module tb_dvv_spi_slave_rsp;

   typedef struct {
      logic [15:0] miso;
      int          nrx;
      logic [15:0] rx;
      int          abort;
      int          und;
      int          und_first;
      logic [7:0]  last;
      logic        ready;
      logic        oe_ok;
      logic        idle_ok;
   } res_t;

   typedef struct {
      int          mode;
      int          nbits;
      logic [15:0] mo;
      bit          pre;
      logic [7:0]  pw;
      bit          mid;
      logic [7:0]  mw;
      res_t        exp;
   } vec_t;

   localparam logic [14:0] RST_VEC = 15'h1000;

   logic       clk = 1'b0;
   logic       resetn;
   logic       sck[4], cs_n[4], mosi[4], miso[4], oe[4];
   logic       tx_valid[4], tx_ready[4], und[4], rxv[4], abrt[4], busy[4];
   logic [7:0] tx_data[4], rx_data[4];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      dvv_spi_slave_rsp #(
         .WIDTH  (8),
         .CPOL   (bit'(g / 2)),
         .CPHA   (bit'(g % 2)),
         .TX_IDLE(8'hFF)
      ) u_dut (
         .clk        (clk),
         .resetn     (resetn),
         .spi_sck    (sck[g]),
         .spi_cs_n   (cs_n[g]),
         .spi_mosi   (mosi[g]),
         .spi_miso   (miso[g]),
         .spi_miso_oe(oe[g]),
         .tx_data    (tx_data[g]),
         .tx_valid   (tx_valid[g]),
         .tx_ready   (tx_ready[g]),
         .tx_underrun(und[g]),
         .rx_data    (rx_data[g]),
         .rx_valid   (rxv[g]),
         .rx_abort   (abrt[g]),
         .busy       (busy[g])
      );
   end

   int         n_tests = 0;
   int         n_fail  = 0;
   int         n_rxv[4], n_und[4], n_abrt[4], und_first[4];
   logic [7:0] rx_seen[4][4];

   // Model state: pending tx words per instance and last received word
   logic [7:0] mq[4][$];
   logic [7:0] last_rx[4];

   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (und[i]) n_und[i]++;
         if (abrt[i]) n_abrt[i]++;
         if (rxv[i]) begin
            if (n_rxv[i] == 0) und_first[i] = n_und[i];
            if (n_rxv[i] < 4) rx_seen[i][n_rxv[i]] = rx_data[i];
            n_rxv[i]++;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [14:0] out_vec(input int m);
      return {miso[m], oe[m], tx_ready[m], und[m], rxv[m], abrt[m], busy[m], rx_data[m]};
   endfunction

   task automatic tx_write(input int m, input logic [7:0] d);
      check($sformatf("m%0d.tx_ready_before_write", m), 32'(tx_ready[m]), 32'd1);
      tx_data[m]  = d;
      tx_valid[m] = 1'b1;
      @(negedge clk);
      tx_valid[m] = 1'b0;
   endtask

   // SPI master: half period 5 clk, CS setup/hold 6 clk, MISO sampled just before the sample edge
   task automatic xfer(input int m, input int n, input logic [15:0] mo, input bit hold,
                       output logic [15:0] mi, output logic oe_ok);
      bit cpol, cpha;
      cpol  = bit'(m / 2);
      cpha  = bit'(m % 2);
      mi    = '0;
      oe_ok = 1'b1;
      sck[m]  = cpol;
      mosi[m] = mo[15];
      cs_n[m] = 1'b0;
      repeat (6) @(negedge clk);
      for (int i = 0; i < n; i++) begin
         if (!cpha) begin
            mosi[m] = mo[15-i];
            repeat (5) @(negedge clk);
            mi[15-i] = miso[m];
            oe_ok    = oe_ok & oe[m] & busy[m];
            sck[m]   = ~cpol;
            repeat (5) @(negedge clk);
            sck[m] = cpol;
         end else begin
            sck[m]  = ~cpol;
            mosi[m] = mo[15-i];
            repeat (5) @(negedge clk);
            mi[15-i] = miso[m];
            oe_ok    = oe_ok & oe[m] & busy[m];
            sck[m]   = cpol;
            repeat (5) @(negedge clk);
         end
      end
      repeat (6) @(negedge clk);
      if (!hold) begin
         cs_n[m] = 1'b1;
         repeat (12) @(negedge clk);
      end
   endtask

   task automatic run_frame(input int m, input int n, input logic [15:0] mo, input bit pre,
                            input logic [7:0] pw, input bit mid, input logic [7:0] mw,
                            output res_t r);
      logic [15:0] mi;
      logic        ok;
      bit          wr_to;
      if (pre) tx_write(m, pw);
      n_rxv[m]      = 0;
      n_und[m]      = 0;
      n_abrt[m]     = 0;
      und_first[m]  = -1;
      rx_seen[m][0] = '0;
      rx_seen[m][1] = '0;
      wr_to         = 1'b0;
      fork
         xfer(m, n, mo, 1'b0, mi, ok);
         begin
            int t;
            t = 0;
            if (mid) begin
               while (!tx_ready[m] && t < 3000) begin
                  @(negedge clk);
                  t++;
               end
               if (t >= 3000) wr_to = 1'b1;
               else tx_write(m, mw);
            end
         end
      join
      if (mid) check($sformatf("m%0d.mid_write_wait_timeout", m), 32'(wr_to), 32'd0);
      r.miso      = mi;
      r.nrx       = n_rxv[m];
      r.rx        = {rx_seen[m][0], rx_seen[m][1]};
      r.abort     = n_abrt[m];
      r.und       = n_und[m];
      r.und_first = und_first[m];
      r.last      = rx_data[m];
      r.ready     = tx_ready[m];
      r.oe_ok     = ok;
      r.idle_ok   = ~busy[m] & ~oe[m];
   endtask

   // Reference: each load point takes the oldest pending write, else TX_IDLE and an underrun.
   // Mode 0/2 loads at CS fall and after every completed word; modes 1/3 at the start of each word.
   task automatic model_frame(input int m, input int n, input logic [15:0] mo, input bit pre,
                              input logic [7:0] pw, input bit mid, input logic [7:0] mw,
                              output res_t e);
      int          loads, words;
      logic [7:0]  w;
      logic [15:0] tmp, mask;
      if (pre) mq[m].push_back(pw);
      words       = (n + 7) / 8;
      loads       = (m % 2 == 0) ? 1 + n / 8 : words;
      e.miso      = '0;
      e.und       = 0;
      e.und_first = -1;
      e.nrx       = n / 8;
      for (int k = 0; k < loads; k++) begin
         if (mq[m].size() > 0) begin
            w = mq[m].pop_front();
         end else begin
            w = 8'hFF;
            e.und++;
         end
         if (k == 0 && e.nrx > 0) e.und_first = e.und;
         if (k == 0 && mid) mq[m].push_back(mw);
         tmp = {w, 8'h00};
         if (k < words) e.miso = e.miso | (tmp >> (8 * k));
      end
      mask    = 16'hFFFF << (16 - n);
      e.miso  = e.miso & mask;
      e.rx    = mo & ((e.nrx >= 2) ? 16'hFFFF : (e.nrx == 1) ? 16'hFF00 : 16'h0000);
      e.abort = (n % 8 != 0) ? 1 : 0;
      if (e.nrx == 1) last_rx[m] = mo[15:8];
      if (e.nrx >= 2) last_rx[m] = mo[7:0];
      e.last    = last_rx[m];
      e.ready   = (mq[m].size() == 0);
      e.oe_ok   = 1'b1;
      e.idle_ok = 1'b1;
   endtask

   task automatic compare(input string tag, input res_t a, input res_t e);
      check({tag, ".miso"}, 32'(a.miso), 32'(e.miso));
      check({tag, ".rx_valid_count"}, a.nrx, e.nrx);
      check({tag, ".rx_words"}, 32'(a.rx), 32'(e.rx));
      check({tag, ".rx_abort_count"}, a.abort, e.abort);
      check({tag, ".underrun_count"}, a.und, e.und);
      check({tag, ".underrun_before_first_rx"}, a.und_first, e.und_first);
      check({tag, ".rx_data_held"}, 32'(a.last), 32'(e.last));
      check({tag, ".tx_ready"}, 32'(a.ready), 32'(e.ready));
      check({tag, ".oe_busy_in_frame"}, 32'(a.oe_ok), 32'(e.oe_ok));
      check({tag, ".idle_after_frame"}, 32'(a.idle_ok), 32'(e.idle_ok));
   endtask

   function automatic vec_t mk(input int mode, input int n, input logic [15:0] mo, input bit pre,
                               input logic [7:0] pw, input bit mid, input logic [7:0] mw,
                               input logic [15:0] e_miso, input int e_nrx,
                               input logic [15:0] e_rx, input int e_abort, input int e_und,
                               input int e_uf, input logic [7:0] e_last);
      vec_t v;
      v.mode          = mode;
      v.nbits         = n;
      v.mo            = mo;
      v.pre           = pre;
      v.pw            = pw;
      v.mid           = mid;
      v.mw            = mw;
      v.exp.miso      = e_miso;
      v.exp.nrx       = e_nrx;
      v.exp.rx        = e_rx;
      v.exp.abort     = e_abort;
      v.exp.und       = e_und;
      v.exp.und_first = e_uf;
      v.exp.last      = e_last;
      v.exp.ready     = 1'b1;
      v.exp.oe_ok     = 1'b1;
      v.exp.idle_ok   = 1'b1;
      return v;
   endfunction

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl[8];
      res_t        act, exp;
      logic [15:0] mi;
      logic        ok;
      int          m, n;
      bit          pre, mid;

      // mode, bits, mosi, pre, pw, mid, mw | miso, nrx, rx, abort, und, und_first, rx_data
      tbl[0] = mk(0, 8,  16'h3C00, 1, 8'hA5, 0, 8'h00, 16'hA500, 1, 16'h3C00, 0, 1,  0, 8'h3C);
      tbl[1] = mk(0, 8,  16'h0000, 0, 8'h00, 0, 8'h00, 16'hFF00, 1, 16'h0000, 0, 2,  1, 8'h00);
      tbl[2] = mk(0, 16, 16'h8142, 1, 8'h11, 1, 8'h22, 16'h1122, 2, 16'h8142, 0, 1,  0, 8'h42);
      tbl[3] = mk(0, 3,  16'hA000, 0, 8'h00, 0, 8'h00, 16'hE000, 0, 16'h0000, 1, 1, -1, 8'h42);
      tbl[4] = mk(0, 8,  16'h5A00, 0, 8'h00, 0, 8'h00, 16'hFF00, 1, 16'h5A00, 0, 2,  1, 8'h5A);
      tbl[5] = mk(1, 8,  16'hC300, 1, 8'hC3, 0, 8'h00, 16'hC300, 1, 16'hC300, 0, 0,  0, 8'hC3);
      tbl[6] = mk(2, 8,  16'hC300, 1, 8'hC3, 0, 8'h00, 16'hC300, 1, 16'hC300, 0, 1,  0, 8'hC3);
      tbl[7] = mk(3, 8,  16'hC300, 1, 8'hC3, 0, 8'h00, 16'hC300, 1, 16'hC300, 0, 0,  0, 8'hC3);

      resetn = 1'b0;
      for (int i = 0; i < 4; i++) begin
         sck[i]      = bit'(i / 2);
         cs_n[i]     = 1'b1;
         mosi[i]     = 1'b0;
         tx_valid[i] = 1'b0;
         tx_data[i]  = '0;
         last_rx[i]  = '0;
         n_rxv[i]    = 0;
         n_und[i]    = 0;
         n_abrt[i]   = 0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) check($sformatf("m%0d.reset_outputs", i), 32'(out_vec(i)),
                                          32'(RST_VEC));
      resetn = 1'b1;
      repeat (5) @(negedge clk);
      for (int i = 0; i < 4; i++) check($sformatf("m%0d.idle_outputs", i), 32'(out_vec(i)),
                                          32'(RST_VEC));

      for (int i = 0; i < 8; i++) begin
         run_frame(tbl[i].mode, tbl[i].nbits, tbl[i].mo, tbl[i].pre, tbl[i].pw, tbl[i].mid,
                   tbl[i].mw, act);
         model_frame(tbl[i].mode, tbl[i].nbits, tbl[i].mo, tbl[i].pre, tbl[i].pw, tbl[i].mid,
                     tbl[i].mw, exp);
         compare($sformatf("vec%0d", i), act, tbl[i].exp);
      end

      // Reset mid-frame: partial word and a full holding buffer are both discarded
      n_abrt[0] = 0;
      xfer(0, 4, 16'h9600, 1'b1, mi, ok);
      tx_write(0, 8'h77);
      resetn = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) check($sformatf("m%0d.midframe_reset_outputs", i),
                                          32'(out_vec(i)), 32'(RST_VEC));
      cs_n[0] = 1'b1;
      repeat (6) @(negedge clk);
      resetn = 1'b1;
      repeat (6) @(negedge clk);
      check("reset_no_abort", n_abrt[0], 0);
      for (int i = 0; i < 4; i++) begin
         mq[i].delete();
         last_rx[i] = '0;
      end
      run_frame(0, 8, 16'h9600, 1'b0, 8'h00, 1'b0, 8'h00, act);
      model_frame(0, 8, 16'h9600, 1'b0, 8'h00, 1'b0, 8'h00, exp);
      compare("after_reset", act, exp);

      for (int it = 0; it < 24; it++) begin
         logic [15:0] mo;
         logic [7:0]  pw, mw;
         m   = $urandom_range(0, 3);
         n   = $urandom_range(1, 16);
         mo  = 16'($urandom);
         pw  = 8'($urandom);
         mw  = 8'($urandom);
         pre = (mq[m].size() == 0) && ($urandom_range(0, 1) == 1);
         mid = pre && ($urandom_range(0, 1) == 1);
         run_frame(m, n, mo, pre, pw, mid, mw, act);
         model_frame(m, n, mo, pre, pw, mid, mw, exp);
         compare($sformatf("rnd%0d_m%0d_n%0d", it, m, n), act, exp);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
